// File: rtl/iter_comp_if.sv
// Compare-request/result bundle for iter_comp: operands and mode in, status and result out.
// Ports: start, signed_mode, a, b (requester to comparator); busy, done, eq, lt, gt (comparator to requester).
// master = requester side, slave = comparator side.
interface iter_comp_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic             lt;
  logic             gt;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, eq, lt, gt
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, eq, lt, gt
  );
endinterface

// File: rtl/iter_comp.sv
// Purpose: multi-cycle magnitude compare of two WIDTH-bit operands, CHUNK bits per cycle MSB-first, early exit.
// Latency: start accepted at edge T; done pulses after edge T+m, m = chunks examined (1..WIDTH/CHUNK).
// Backpressure: none; start is only sampled while idle (busy=0) and ignored otherwise.
// Ports: clk, rst_n (synchronous, active-low); cif.slave carries start/signed_mode/a/b in and
//        busy/done/eq/lt/gt out. All outputs are registered. WIDTH must be a multiple of CHUNK.
module iter_comp #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  iter_comp_if.slave  cif
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NCH - 1);
  // Only bit WIDTH-1 set; written without a zero-width replication so WIDTH=1 still elaborates.
  localparam logic [WIDTH-1:0] MSB_MASK = {WIDTH{1'b1}} ^ ({WIDTH{1'b1}} >> 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;

  // The chunk under test always sits at the top of the operand registers: each equal
  // chunk shifts both operands left, so no variable part-select is needed.
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  assign chunk_a = a_q[WIDTH-1 -: CHUNK];
  assign chunk_b = b_q[WIDTH-1 -: CHUNK];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;

    case (state_q)
      IDLE: begin
        if (cif.start) begin
          state_d = RUN;
          // Signed mode is folded in at capture: flipping both sign bits turns the
          // two's-complement order into the unsigned order, so no mode flop is kept.
          a_d     = cif.a ^ (cif.signed_mode ? MSB_MASK : '0);
          b_d     = cif.b ^ (cif.signed_mode ? MSB_MASK : '0);
          idx_d   = IDX_TOP;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
        end
      end
      RUN: begin
        if (chunk_a > chunk_b) begin
          gt_d    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (chunk_a < chunk_b) begin
          lt_d    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - IDXW'(1);
          a_d   = a_q << CHUNK;
          b_d   = b_q << CHUNK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= IDX_TOP;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
    end
  end

  // busy is the state flop itself, so it drops on the same edge that raises done.
  assign cif.busy = (state_q == RUN);
  assign cif.done = done_q;
  assign cif.eq   = eq_q;
  assign cif.lt   = lt_q;
  assign cif.gt   = gt_q;

endmodule

// File: tb/tb_iter_comp.sv
// Bench for iter_comp: 16/4 and 8/4 instances, vector table, hand sequences, random and swept checks.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected results come from a reference that orders integer values and finds the first differing prefix.
module tb_iter_comp;

  logic clk;
  logic rst_n;

  iter_comp_if #(.WIDTH(16)) c16 ();
  iter_comp_if #(.WIDTH(8))  c8  ();

  iter_comp #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst_n(rst_n), .cif(c16));
  iter_comp #(.WIDTH(8),  .CHUNK(4)) dut8  (.clk(clk), .rst_n(rst_n), .cif(c8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [2:0] F_EQ = 3'b100;
  localparam logic [2:0] F_LT = 3'b010;
  localparam logic [2:0] F_GT = 3'b001;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: order the operands as integers, latency = first MSB-aligned prefix that differs.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input bit sm,
                                input int w, input int ch, output logic [2:0] fl, output int lat);
    longint av, bv;
    av = a;
    bv = b;
    if (sm && a[w-1]) av = av - (64'sd1 <<< w);
    if (sm && b[w-1]) bv = bv - (64'sd1 <<< w);
    fl  = (av == bv) ? F_EQ : (av < bv) ? F_LT : F_GT;
    lat = w / ch;
    for (int k = 1; k <= w / ch; k++) begin
      if ((a >> (w - k * ch)) != (b >> (w - k * ch))) begin
        lat = k;
        break;
      end
    end
  endfunction

  // Called at a falling edge; returns at the falling edge where done is seen (or after a bound).
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input bit sm,
                       output logic [2:0] fl, output int lat, output bit seen);
    c16.start = 1'b1; c16.a = a; c16.b = b; c16.signed_mode = sm;
    @(negedge clk);
    c16.start = 1'b0;
    lat = 0;
    while (!c16.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    seen = c16.done;
    fl   = {c16.eq, c16.lt, c16.gt};
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit sm,
                      output logic [2:0] fl, output int lat, output bit seen);
    c8.start = 1'b1; c8.a = a; c8.b = b; c8.signed_mode = sm;
    @(negedge clk);
    c8.start = 1'b0;
    lat = 0;
    while (!c8.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    seen = c8.done;
    fl   = {c8.eq, c8.lt, c8.gt};
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          sm;
    logic [2:0]  exp_fl;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [2:0]  fl, efl;
    int          lat, elat;
    bit          seen;
    logic [7:0]  vals[16];
    logic [15:0] ra, rb;
    bit          rsm;

    vecs[0] = '{16'h9000, 16'h1FFF, 1'b0, F_GT, 1};
    vecs[1] = '{16'h1234, 16'h1235, 1'b0, F_LT, 4};
    vecs[2] = '{16'hABCD, 16'hABCD, 1'b0, F_EQ, 4};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b1, F_LT, 1};
    vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, F_GT, 1};
    vecs[5] = '{16'h8000, 16'h7FFF, 1'b1, F_LT, 1};
    vecs[6] = '{16'h0F00, 16'h0F10, 1'b0, F_LT, 3};
    vecs[7] = '{16'h7FFF, 16'h7FFE, 1'b1, F_GT, 4};

    vals = '{8'h00, 8'h01, 8'h07, 8'h08, 8'h0F, 8'h10, 8'h11, 8'h70,
             8'h7F, 8'h80, 8'h81, 8'h8F, 8'hF0, 8'hF7, 8'hFE, 8'hFF};

    // Reset held with start asserted: nothing may start.
    rst_n = 1'b0;
    c16.start = 1'b1; c16.a = 16'h9000; c16.b = 16'h1FFF; c16.signed_mode = 1'b0;
    c8.start = 1'b0; c8.a = '0; c8.b = '0; c8.signed_mode = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",  c16.busy, 0);
    check("rst_done",  c16.done, 0);
    check("rst_flags", {c16.eq, c16.lt, c16.gt}, 3'b000);
    check("rst_busy8", c8.busy, 0);

    // Release: the still-asserted start is taken on the next edge.
    rst_n = 1'b1;
    @(negedge clk);
    c16.start = 1'b0;
    check("post_rst_busy",  c16.busy, 1);
    check("post_rst_done",  c16.done, 0);
    @(negedge clk);
    check("post_rst_done1", c16.done, 1);
    check("post_rst_flags", {c16.eq, c16.lt, c16.gt}, F_GT);
    check("post_rst_busy0", c16.busy, 0);
    @(negedge clk);
    check("done_one_cycle", c16.done, 0);
    check("result_holds",   {c16.eq, c16.lt, c16.gt}, F_GT);

    // Vector table.
    foreach (vecs[i]) begin
      run16(vecs[i].a, vecs[i].b, vecs[i].sm, fl, lat, seen);
      check($sformatf("vec%0d_done", i),  seen, 1);
      check($sformatf("vec%0d_flags", i), fl, vecs[i].exp_fl);
      check($sformatf("vec%0d_lat", i),   lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_busy", i),  c16.busy, 0);
    end

    // Back-to-back: start in the done cycle is accepted at once.
    c16.start = 1'b1; c16.a = 16'h0001; c16.b = 16'h0000; c16.signed_mode = 1'b0;
    @(negedge clk);
    c16.start = 1'b0;
    check("b2b_done_fell", c16.done, 0);
    check("b2b_busy",      c16.busy, 1);
    check("b2b_cleared",   {c16.eq, c16.lt, c16.gt}, 3'b000);
    lat = 0;
    while (!c16.done && lat < 20) begin @(negedge clk); lat++; end
    check("b2b_flags", {c16.eq, c16.lt, c16.gt}, F_GT);
    check("b2b_lat",   lat, 4);

    // Start while busy with new operands is ignored.
    c16.start = 1'b1; c16.a = 16'h1234; c16.b = 16'h1235; c16.signed_mode = 1'b0;
    @(negedge clk);
    c16.start = 1'b0;
    lat = 0;
    @(negedge clk); lat++;
    c16.start = 1'b1; c16.a = 16'hFFFF; c16.b = 16'h0000; c16.signed_mode = 1'b1;
    @(negedge clk); lat++;
    c16.start = 1'b0;
    while (!c16.done && lat < 20) begin @(negedge clk); lat++; end
    check("busy_start_flags", {c16.eq, c16.lt, c16.gt}, F_LT);
    check("busy_start_lat",   lat, 4);
    @(negedge clk);
    check("busy_start_idle",  c16.busy, 0);

    // Reset in the middle of a full-length compare: no done, all cleared.
    c16.start = 1'b1; c16.a = 16'hABCD; c16.b = 16'hABCD; c16.signed_mode = 1'b0;
    @(negedge clk);
    c16.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy",  c16.busy, 0);
    check("midrst_flags", {c16.eq, c16.lt, c16.gt}, 3'b000);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (c16.done) seen = 1'b1;
    end
    check("midrst_no_done", seen, 0);
    check("midrst_flags_after", {c16.eq, c16.lt, c16.gt}, 3'b000);

    // Randomized 16-bit compares, biased toward shared prefixes.
    for (int i = 0; i < 150; i++) begin
      ra  = 16'($urandom);
      rsm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rb = 16'($urandom);
        1:       rb = ra;
        2:       rb = ra ^ (16'h0001 << $urandom_range(0, 15));
        default: rb = ra ^ 16'($urandom_range(1, 15));
      endcase
      model(ra, rb, rsm, 16, 4, efl, elat);
      run16(ra, rb, rsm, fl, lat, seen);
      check($sformatf("rnd%0d_done", i),  seen, 1);
      check($sformatf("rnd%0d_flags", i), fl, efl);
      check($sformatf("rnd%0d_lat", i),   lat, elat);
    end

    // 8-bit sweep over 256 boundary-heavy pairs, both modes.
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          model({8'h00, vals[i]}, {8'h00, vals[j]}, m[0], 8, 4, efl, elat);
          run8(vals[i], vals[j], m[0], fl, lat, seen);
          if (!seen) check($sformatf("sw_m%0d_%0h_%0h_done", m, vals[i], vals[j]), seen, 1);
          check($sformatf("sw_m%0d_%0h_%0h_flags", m, vals[i], vals[j]), fl, efl);
          check($sformatf("sw_m%0d_%0h_%0h_lat", m, vals[i], vals[j]), lat, elat);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
